// File: rtl/apb_rf_pkg.sv
// ==== apb_rf_pkg : shared state encoding and address-check helper (rev 1.0) ====
`default_nettype none

package apb_rf_pkg;

  localparam int unsigned ADDR_LSB = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_DONE = 3'd3,
    ST_ERR     = 3'd4
  } apb_rf_state_e;

  // paddr arrives zero-extended, so bits above the real bus width never flag.
  function automatic logic addr_err(input logic [31:0] paddr, input int unsigned addr_w);
    logic [31:0] upper;
    upper = paddr >> (addr_w + ADDR_LSB);
    return (paddr[ADDR_LSB-1:0] != '0) || (upper != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_regfile_bridge_addr_dec.sv
// ==== apb_rf_addr_dec : byte address to register index and error flag (rev 1.0) ====
`default_nettype none

module apb_rf_addr_dec
  import apb_rf_pkg::*;
#(
  parameter int ADDR    = 4,
  parameter int PADDR_W = 8
) (
  input  logic [PADDR_W-1:0] i_paddr,
  output logic [ADDR-1:0]    o_index,
  output logic               o_err
);

  logic [31:0] w_paddr_ext;

  always_comb begin
    w_paddr_ext                = '0;
    w_paddr_ext[PADDR_W-1:0]   = i_paddr;
  end

  assign o_index = i_paddr[ADDR+ADDR_LSB-1:ADDR_LSB];
  assign o_err   = addr_err(w_paddr_ext, ADDR);

endmodule

`default_nettype wire

// File: rtl/apb_regfile_bridge.sv
// ==== apb_regfile_bridge : APB3 slave driving register-file strobes (rev 1.0) ====
// Define APB_RF_PSLVERR_EN to answer misaligned/out-of-range addresses with PSLVERR.
`default_nettype none

module apb_regfile_bridge
  import apb_rf_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR    = 4,
  parameter int PADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [PADDR_W-1:0] PADDR,
  input  logic [WIDTH-1:0]   PWDATA,
  output logic [WIDTH-1:0]   PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  output logic               WrEn,
  output logic               RdEn,
  output logic [ADDR-1:0]    Address,
  output logic [WIDTH-1:0]   WrData,
  input  logic [WIDTH-1:0]   RdData
);

  apb_rf_state_e      r_state;
  logic               r_wr_en;
  logic               r_rd_en;
  logic               r_ready;
  logic [ADDR-1:0]    r_addr;
  logic [WIDTH-1:0]   r_wdata;
  logic [ADDR-1:0]    w_index;
  logic               w_addr_err;

  apb_rf_addr_dec #(
    .ADDR    (ADDR),
    .PADDR_W (PADDR_W)
  ) u_addr_dec (
    .i_paddr (PADDR),
    .o_index (w_index),
    .o_err   (w_addr_err)
  );

`ifdef APB_RF_PSLVERR_EN
  logic r_slverr;
  assign PSLVERR = r_slverr;
`else
  logic w_unused;
  assign w_unused = w_addr_err;
  assign PSLVERR  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_ready <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef APB_RF_PSLVERR_EN
      r_slverr <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Only the setup phase starts a transfer; a stray access phase is ignored.
          if (PSEL && !PENABLE) begin
            r_addr  <= w_index;
            r_wdata <= PWDATA;
`ifdef APB_RF_PSLVERR_EN
            if (w_addr_err) begin
              r_state  <= ST_ERR;
              r_ready  <= 1'b1;
              r_slverr <= 1'b1;
            end else
`endif
            if (PWRITE) begin
              r_state <= ST_WR;
              r_wr_en <= 1'b1;
              r_ready <= 1'b1;
            end else begin
              r_state <= ST_RD;
              r_rd_en <= 1'b1;
            end
          end
        end
        ST_WR: begin
          r_state <= ST_IDLE;
          r_wr_en <= 1'b0;
          r_ready <= 1'b0;
        end
        ST_RD: begin
          r_rd_en <= 1'b0;
          if (PSEL && PENABLE) begin
            r_state <= ST_RD_DONE;
            r_ready <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
`ifdef APB_RF_PSLVERR_EN
        ST_ERR: begin
          r_state  <= ST_IDLE;
          r_ready  <= 1'b0;
          r_slverr <= 1'b0;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_wr_en <= 1'b0;
          r_rd_en <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // The register file holds RdData stable through RD_DONE, so gating it by state suffices.
  assign PRDATA  = (r_state == ST_RD_DONE) ? RdData : '0;
  assign PREADY  = r_ready;
  assign WrEn    = r_wr_en;
  assign RdEn    = r_rd_en;
  assign Address = r_addr;
  assign WrData  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_regfile_bridge.sv
// ==== tb_apb_regfile_bridge : scoreboard bench for apb_regfile_bridge (rev 1.0) ====
`default_nettype none

module tb_apb_regfile_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [7:0]  PADDR = 8'h00;
  logic [31:0] PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        WrEn;
  logic        RdEn;
  logic [3:0]  Address;
  logic [31:0] WrData;
  logic [31:0] RdData;

  apb_regfile_bridge #(.WIDTH(32), .ADDR(4), .PADDR_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .WrEn    (WrEn),
    .RdEn    (RdEn),
    .Address (Address),
    .WrData  (WrData),
    .RdData  (RdData)
  );

  always #5 clk = ~clk;

  // Register file behind the bridge: one-cycle registered read.
  logic [31:0] rf_mem [16] = '{default: 32'h0};
  always @(posedge clk) begin
    if (WrEn) rf_mem[Address] <= WrData;
    if (RdEn) RdData <= rf_mem[Address];
  end

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          waits;
    int          nwr;
    int          nrd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  int          tests_run = 0;
  int          tests_failed = 0;
  int          both_cnt = 0;

  always @(posedge clk) if (WrEn && RdEn) both_cnt++;

  task automatic idle_cycle();
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data, input string name);
    exp_t        e;
    exp_t        g;
    logic [3:0]  idx;
    logic        done;
    int          nwr;
    int          nrd;
    int          waits;
    logic [31:0] rdata;
    logic        err;
    idx = addr[5:2];
`ifdef APB_RF_PSLVERR_EN
    e.err = (addr[1:0] != 2'b00) || (addr[7:6] != 2'b00);
`else
    e.err = 1'b0;
`endif
    e.waits = (!wr && !e.err) ? 1 : 0;
    e.nwr   = (wr && !e.err) ? 1 : 0;
    e.nrd   = (!wr && !e.err) ? 1 : 0;
    e.data  = (!wr && !e.err) ? ref_mem[idx] : 32'h0;
    if (wr && !e.err) ref_mem[idx] = data;
    sb.push_back(e);

    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    done = 1'b0; nwr = 0; nrd = 0; waits = 0; rdata = 32'h0; err = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (WrEn) nwr++;
      if (RdEn) nrd++;
      if (c == 0 && !e.err) begin
        tests_run++;
        if (Address !== idx || (wr && WrData !== data)) begin
          tests_failed++;
          $display("FAIL %s addr: Address=%0d WrData=%h expected Address=%0d WrData=%h", name, Address, WrData, idx, data);
        end
      end
      if (PREADY) begin
        done = 1'b1; rdata = PRDATA; err = PSLVERR;
      end else begin
        waits++;
      end
    end

    g = sb.pop_front();
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL %s timeout: no PREADY within 8 cycles", name);
    end else if (rdata !== g.data || err !== g.err || waits != g.waits || nwr != g.nwr || nrd != g.nrd) begin
      tests_failed++;
      $display("FAIL %s: got prdata=%h err=%b waits=%0d wr=%0d rd=%0d expected prdata=%h err=%b waits=%0d wr=%0d rd=%0d",
               name, rdata, err, waits, nwr, nrd, g.data, g.err, g.waits, g.nwr, g.nrd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({PRDATA, PREADY, PSLVERR, WrEn, RdEn, Address, WrData} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: outputs=%h expected 0", {PRDATA, PREADY, PSLVERR, WrEn, RdEn, Address, WrData});
    end
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'hFFFF_FFFF;
    @(negedge clk);
    tests_run++;
    if ({PREADY, WrEn, RdEn, Address, WrData} !== '0) begin
      tests_failed++;
      $display("FAIL reset_hold: outputs=%h expected 0", {PREADY, WrEn, RdEn, Address, WrData});
    end
    @(posedge clk); #1;
    PSEL = 1'b0; rst = 1'b1;
  endtask

  task automatic test_read_all();
    for (int i = 0; i < 16; i++) apb_xfer(1'b0, 8'(i * 4), 32'h0, "read_all");
    idle_cycle();
  endtask

  task automatic test_write_read();
    apb_xfer(1'b1, 8'h08, 32'hDEAD_BEEF, "write_08");
    idle_cycle();
    apb_xfer(1'b0, 8'h08, 32'h0, "read_08");
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    apb_xfer(1'b1, 8'h3C, 32'h1234_5678, "b2b_write_3c");
    apb_xfer(1'b0, 8'h3C, 32'h0, "b2b_read_3c");
    apb_xfer(1'b1, 8'h04, 32'hA5A5_0F0F, "b2b_write_04");
    apb_xfer(1'b0, 8'h04, 32'h0, "b2b_read_04");
    apb_xfer(1'b0, 8'h08, 32'h0, "b2b_read_08");
    idle_cycle();
  endtask

`ifdef APB_RF_PSLVERR_EN
  task automatic test_addr_err();
    apb_xfer(1'b1, 8'h00, 32'h1111_1111, "err_seed_00");
    apb_xfer(1'b1, 8'h41, 32'hBAD0_0001, "err_write_41");
    apb_xfer(1'b1, 8'h40, 32'hBAD0_0002, "err_write_40");
    apb_xfer(1'b0, 8'h00, 32'h0, "err_read_00");
    apb_xfer(1'b0, 8'h82, 32'h0, "err_read_82");
    idle_cycle();
  endtask
`else
  task automatic test_alias();
    apb_xfer(1'b1, 8'hC9, 32'h0BAD_F00D, "alias_write_c9");
    apb_xfer(1'b0, 8'h08, 32'h0, "alias_read_08");
    apb_xfer(1'b0, 8'h4B, 32'h0, "alias_read_4b");
    idle_cycle();
  endtask
`endif

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h3C;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    tests_run++;
    if (RdEn !== 1'b1 || PREADY !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_pre: RdEn=%b PREADY=%b expected RdEn=1 PREADY=0", RdEn, PREADY);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({PRDATA, PREADY, PSLVERR, WrEn, RdEn, Address, WrData} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: outputs=%h expected 0", {PRDATA, PREADY, PSLVERR, WrEn, RdEn, Address, WrData});
    end
    @(posedge clk); #1;
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    apb_xfer(1'b1, 8'h14, 32'hC0FF_EE00, "midrst_write_14");
    apb_xfer(1'b0, 8'h14, 32'h0, "midrst_read_14");
    idle_cycle();
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h08;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
    tests_run++;
    if (RdEn !== 1'b1 || PREADY !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_rd: RdEn=%b PREADY=%b expected RdEn=1 PREADY=0", RdEn, PREADY);
    end
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h5555_AAAA;
    @(negedge clk);
    tests_run++;
    if (PREADY !== 1'b0 || RdEn !== 1'b0 || WrEn !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: PREADY=%b RdEn=%b WrEn=%b expected all 0", PREADY, RdEn, WrEn);
    end
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    tests_run++;
    if (WrEn !== 1'b1 || PREADY !== 1'b1 || Address !== 4'd3) begin
      tests_failed++;
      $display("FAIL abort_next_setup: WrEn=%b PREADY=%b Address=%0d expected 1 1 3", WrEn, PREADY, Address);
    end
    ref_mem[3] = 32'h5555_AAAA;
    idle_cycle();
    apb_xfer(1'b0, 8'h0C, 32'h0, "abort_read_0c");
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_write_read();
    test_back_to_back();
`ifdef APB_RF_PSLVERR_EN
    test_addr_err();
`else
    test_alias();
`endif
    test_reset_mid_read();
    test_abort();
    tests_run++;
    if (both_cnt != 0) begin
      tests_failed++;
      $display("FAIL enable_overlap: cycles with WrEn&RdEn=%0d expected 0", both_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
